// File: rtl/weight_injector.sv
// Weight injector: streams COLS weights per grid row out of the weight buffer,
// assembles them into a row vector and hands each row to the PE grid with a tag.
//
// state    | meaning
// ST_IDLE  | waiting for start; config checked here
// ST_FETCH | one buffer read per cycle, columns 0..COLS-1
// ST_WAIT  | last column's read data lands
// ST_ISSUE | row presented to the grid until accepted (stall low)
// ST_DONE  | one-cycle completion pulse
module weight_injector #(
  parameter int DATA_WIDTH = 16,
  parameter int COLS       = 14,
  parameter int ROWS       = 12,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      cfg_base_addr,
  input  logic [ID_WIDTH-1:0]        cfg_first_row,
  input  logic [ID_WIDTH-1:0]        cfg_num_rows,
  output logic                       rd_req,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  input  logic                       stall,
  output logic [COLS*DATA_WIDTH-1:0] row_weight_vals,
  output logic [ID_WIDTH-1:0]        tag_row,
  output logic                       valid_y,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int COL_W = $clog2(COLS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [ID_WIDTH-1:0]        first_row_q;
  logic [ID_WIDTH-1:0]        num_rows_q;
  logic [ID_WIDTH-1:0]        row_idx;
  logic [COL_W-1:0]           col_idx;
  logic                       cap_pend;
  logic [COL_W-1:0]           cap_col;
  logic [COLS*DATA_WIDTH-1:0] vals_q;
  logic [ID_WIDTH-1:0]        tag_q;
  logic                       err_q;

  logic [ID_WIDTH:0] row_end;
  logic              cfg_legal;
  logic              last_col;
  logic              last_row;
  logic              launch;

  assign row_end   = {1'b0, cfg_first_row} + {1'b0, cfg_num_rows};
  assign cfg_legal = (cfg_num_rows != '0) && (row_end <= (ID_WIDTH+1)'(ROWS));
  assign last_col  = (col_idx == COL_W'(COLS - 1));
  assign last_row  = ((row_idx + ID_WIDTH'(1)) == num_rows_q);
  assign launch    = (state == ST_IDLE) && start && cfg_legal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (launch) state_nxt = ST_FETCH;
      ST_FETCH: if (last_col) state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_ISSUE;
      ST_ISSUE: if (!stall) state_nxt = last_row ? ST_DONE : ST_FETCH;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Rows are contiguous in the buffer, so one running address covers
  // base + row*COLS + col without a multiplier; it wraps at 2^ADDR_WIDTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      first_row_q <= '0;
      num_rows_q  <= '0;
      row_idx     <= '0;
      col_idx     <= '0;
      cap_pend    <= 1'b0;
      cap_col     <= '0;
      vals_q      <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q    <= (state == ST_IDLE) && start && !cfg_legal;
      cap_pend <= (state == ST_FETCH);
      cap_col  <= col_idx;
      if (cap_pend)
        vals_q[cap_col*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            addr_q      <= cfg_base_addr;
            first_row_q <= cfg_first_row;
            num_rows_q  <= cfg_num_rows;
            row_idx     <= '0;
            col_idx     <= '0;
          end
        end
        ST_FETCH: begin
          addr_q  <= addr_q + ADDR_WIDTH'(1);
          col_idx <= last_col ? '0 : col_idx + COL_W'(1);
        end
        ST_WAIT: tag_q <= first_row_q + row_idx;
        ST_ISSUE: begin
          if (!stall && !last_row) row_idx <= row_idx + ID_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign rd_req          = (state == ST_FETCH);
  assign rd_addr         = addr_q;
  assign row_weight_vals = vals_q;
  assign tag_row         = tag_q;
  assign valid_y         = (state == ST_ISSUE);
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);
  assign err             = err_q;

endmodule
